// File: rtl/aes_control_unit.sv
// Round sequencer for the AES-128 encryption datapath: KEY, ARK0, rounds 1-10, then DONE/ERR.
// Latency: at least 2 cycles per stage state; DONE 82 edges after start with ideal done flags.
// Backpressure: DONE/ERR hold until out_ack; a stage waits for its done flag, bounded by the watchdog.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   start, out_ack       begin encryption (IDLE only); release DONE/ERR
//   *_done               stage completion flags from the datapath
//   *_en                 one-hot stage enables
//   data_sel_init/final  AddRoundKey input selects (plaintext / ShiftRows output)
//   data_out_en, done    ciphertext valid until out_ack
//   error                watchdog fired, held until out_ack
//   round_count, busy    round-key index 0-10, sequencing in progress
module aes_control_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       out_ack,
    input  logic       key_expan_done,
    input  logic       add_key_done,
    input  logic       sub_bytes_done,
    input  logic       shift_rows_done,
    input  logic       mix_columns_done,
    output logic       key_expan_en,
    output logic       add_roundkey_en,
    output logic       sub_bytes_en,
    output logic       shift_rows_en,
    output logic       mix_columns_en,
    output logic       data_sel_init,
    output logic       data_sel_final,
    output logic       data_out_en,
    output logic [3:0] round_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_ARK0, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [3:0] round, round_nxt;
    logic [7:0] cnt;
    logic       is_stage;
    logic       stage_flag;
    logic       stage_adv;
    logic       stage_tmo;

    // Every stage state is left on its own transition, so a state change marks
    // entry into the next state and restarts the dwell counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            round <= 4'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            round <= round_nxt;
            if (state_nxt != state)
                cnt <= 8'd0;
            else if (is_stage)
                cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        round_nxt  = round;
        is_stage   = 1'b1;
        stage_flag = 1'b0;
        stage_adv  = 1'b0;
        stage_tmo  = 1'b0;

        // Only the flag of the current stage is looked at.
        case (state)
            S_KEY:          stage_flag = key_expan_done;
            S_ARK0, S_ARK:  stage_flag = add_key_done;
            S_SUB:          stage_flag = sub_bytes_done;
            S_SHIFT:        stage_flag = shift_rows_done;
            S_MIX:          stage_flag = mix_columns_done;
            default:        is_stage   = 1'b0;
        endcase

        // cnt == 0 is the first cycle of the state: a flag left high by the
        // previous stage must not advance us. Since TO_LAST >= 1, a flag
        // arriving on the last allowed cycle still advances (done beats timeout).
        stage_adv = is_stage && (cnt != 8'd0) && stage_flag;
        stage_tmo = is_stage && !stage_flag && (cnt == TO_LAST);

        case (state)
            S_IDLE:  if (start) state_nxt = S_KEY;
            S_KEY:   if (stage_adv) state_nxt = S_ARK0;
            S_ARK0: begin
                if (stage_adv) begin
                    state_nxt = S_SUB;
                    round_nxt = 4'd1;
                end
            end
            S_SUB:   if (stage_adv) state_nxt = S_SHIFT;
            S_SHIFT: if (stage_adv) state_nxt = (round == 4'd10) ? S_ARK : S_MIX;
            S_MIX:   if (stage_adv) state_nxt = S_ARK;
            S_ARK: begin
                if (stage_adv) begin
                    if (round < 4'd10) begin
                        state_nxt = S_SUB;
                        round_nxt = round + 4'd1;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE, S_ERR: begin
                // start in the same cycle is dropped; IDLE samples it afresh.
                if (out_ack) begin
                    state_nxt = S_IDLE;
                    round_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                round_nxt = 4'd0;
            end
        endcase

        // round is left untouched so ERR reports where the stall happened.
        if (stage_tmo)
            state_nxt = S_ERR;
    end

    // Moore outputs: decoded from state and round only.
    always_comb begin
        key_expan_en    = 1'b0;
        add_roundkey_en = 1'b0;
        sub_bytes_en    = 1'b0;
        shift_rows_en   = 1'b0;
        mix_columns_en  = 1'b0;
        data_sel_init   = 1'b0;
        data_sel_final  = 1'b0;
        data_out_en     = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        round_count     = round;

        case (state)
            S_KEY:   begin key_expan_en = 1'b1; busy = 1'b1; end
            S_ARK0:  begin add_roundkey_en = 1'b1; data_sel_init = 1'b1; busy = 1'b1; end
            S_SUB:   begin sub_bytes_en = 1'b1; busy = 1'b1; end
            S_SHIFT: begin shift_rows_en = 1'b1; busy = 1'b1; end
            S_MIX:   begin mix_columns_en = 1'b1; busy = 1'b1; end
            S_ARK:   begin add_roundkey_en = 1'b1; busy = 1'b1; end
            S_DONE:  begin data_out_en = 1'b1; done = 1'b1; data_sel_final = 1'b1; end
            S_ERR:   error = 1'b1;
            default: ;
        endcase

        if ((state == S_SUB || state == S_SHIFT || state == S_ARK) && round == 4'd10)
            data_sel_final = 1'b1;
    end

endmodule

// File: tb/tb_aes_control_unit.sv
module tb_aes_control_unit;

    localparam int TIMEOUT = 16;
    localparam int K_KEY = 0, K_ARK0 = 1, K_SUB = 2, K_SHIFT = 3, K_MIX = 4, K_ARK = 5;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;
    localparam int NSTAGE = 41;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0, out_ack = 1'b0;
    logic       key_expan_done = 1'b0, add_key_done = 1'b0, sub_bytes_done = 1'b0;
    logic       shift_rows_done = 1'b0, mix_columns_done = 1'b0;
    logic       key_expan_en, add_roundkey_en, sub_bytes_en, shift_rows_en, mix_columns_en;
    logic       data_sel_init, data_sel_final, data_out_en, busy, done, error;
    logic [3:0] round_count;

    int vectors = 0;
    int miscompares = 0;

    aes_control_unit #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .start(start), .out_ack(out_ack),
        .key_expan_done(key_expan_done), .add_key_done(add_key_done),
        .sub_bytes_done(sub_bytes_done), .shift_rows_done(shift_rows_done),
        .mix_columns_done(mix_columns_done),
        .key_expan_en(key_expan_en), .add_roundkey_en(add_roundkey_en),
        .sub_bytes_en(sub_bytes_en), .shift_rows_en(shift_rows_en),
        .mix_columns_en(mix_columns_en), .data_sel_init(data_sel_init),
        .data_sel_final(data_sel_final), .data_out_en(data_out_en),
        .round_count(round_count), .busy(busy), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    // Reference model: the encryption is a flat list of 41 stages; the model
    // keeps a position in that list plus the cycles spent at that position.
    int seq_kind[NSTAGE];
    int seq_rnd[NSTAGE];
    int m_mode = M_IDLE;
    int m_idx = 0;
    int m_dwell = 0;

    function automatic void build_seq();
        int n = 0;
        seq_kind[n] = K_KEY;  seq_rnd[n] = 0; n++;
        seq_kind[n] = K_ARK0; seq_rnd[n] = 0; n++;
        for (int r = 1; r <= 10; r++) begin
            seq_kind[n] = K_SUB;   seq_rnd[n] = r; n++;
            seq_kind[n] = K_SHIFT; seq_rnd[n] = r; n++;
            if (r < 10) begin seq_kind[n] = K_MIX; seq_rnd[n] = r; n++; end
            seq_kind[n] = K_ARK;   seq_rnd[n] = r; n++;
        end
    endfunction

    // Flag bit order: {mix, shift, sub, add, key}.
    function automatic int flag_bit(input int kind);
        case (kind)
            K_KEY:        return 0;
            K_ARK0, K_ARK: return 1;
            K_SUB:        return 2;
            K_SHIFT:      return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic int cur_kind();
        return (m_mode == M_RUN) ? seq_kind[m_idx] : -1;
    endfunction

    function automatic int cur_rnd();
        return (m_mode == M_RUN) ? seq_rnd[m_idx] : -1;
    endfunction

    function automatic void model_step(input logic st, input logic ack, input logic [4:0] fl);
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_RUN; m_idx = 0; m_dwell = 0; end
            M_RUN: begin
                if (m_dwell >= 1 && fl[flag_bit(seq_kind[m_idx])]) begin
                    m_dwell = 0;
                    if (m_idx == NSTAGE - 1) m_mode = M_DONE;
                    else m_idx++;
                end else if (m_dwell == TIMEOUT - 1) begin
                    m_mode = M_ERR;
                end else begin
                    m_dwell++;
                end
            end
            default: if (ack) m_mode = M_IDLE;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idx = 0; m_dwell = 0;
    endfunction

    // {key_en, ark_en, sub_en, shift_en, mix_en, sel_init, sel_final, out_en, round[3:0], busy, done, error}
    function automatic logic [14:0] exp_vec();
        logic [4:0] en = 5'b0;
        logic si = 1'b0, sf = 1'b0, oe = 1'b0, b = 1'b0, d = 1'b0, e = 1'b0;
        logic [3:0] rc = 4'd0;
        if (m_mode == M_RUN) begin
            en[4 - flag_bit(seq_kind[m_idx])] = 1'b1;
            si = (seq_kind[m_idx] == K_ARK0);
            rc = 4'(seq_rnd[m_idx]);
            sf = (rc == 4'd10);
            b  = 1'b1;
        end else if (m_mode == M_DONE) begin
            sf = 1'b1; oe = 1'b1; d = 1'b1; rc = 4'd10;
        end else if (m_mode == M_ERR) begin
            e = 1'b1; rc = 4'(seq_rnd[m_idx]);
        end
        return {en, si, sf, oe, rc, b, d, e};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {key_expan_en, add_roundkey_en, sub_bytes_en, shift_rows_en, mix_columns_en,
                data_sel_init, data_sel_final, data_out_en, round_count, busy, done, error};
    endfunction

    function automatic logic [4:0] ideal_flags();
        logic [4:0] f = 5'b0;
        if (m_mode == M_RUN && m_dwell >= 1) f[flag_bit(seq_kind[m_idx])] = 1'b1;
        return f;
    endfunction

    // Drive inputs, clock one edge, advance the model, settle away from the edge.
    task automatic tick(input logic st, input logic ack, input logic [4:0] fl);
        start = st; out_ack = ack;
        {mix_columns_done, shift_rows_done, sub_bytes_done, add_key_done, key_expan_done} = fl;
        @(posedge CLK);
        model_step(st, ack, fl);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #3;
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL reset_outputs got %h want 0000", dut_vec());
        end
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        tick(1'b0, 1'b1, 5'b11111);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL reset_idle got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_nominal();
        int edges = 0;
        tick(1'b1, 1'b0, 5'b0);
        while (done !== 1'b1 && error !== 1'b1 && edges < 200) begin
            tick(1'b0, 1'b0, ideal_flags());
            edges++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL nominal edge %0d got %h want %h", edges, dut_vec(), exp_vec());
            end
            if (mix_columns_en === 1'b1 && round_count == 4'd10) begin
                miscompares++; $display("FAIL nominal_mix_r10 at edge %0d", edges);
            end
        end
        vectors++;
        if (edges != 82 || done !== 1'b1) begin
            miscompares++; $display("FAIL nominal_latency got %0d edges done=%b want 82 done=1", edges, done);
        end
        tick(1'b0, 1'b1, 5'b0);
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL nominal_ack got %h want 0000", dut_vec());
        end
    endtask

    task automatic test_stale();
        int edges = 0, run = 0;
        tick(1'b1, 1'b0, 5'b00100);
        while (done !== 1'b1 && error !== 1'b1 && edges < 200) begin
            tick(1'b0, 1'b0, ideal_flags() | 5'b00100);
            edges++;
            vectors++;
            if (dut_vec() !== exp_vec() || $countones(dut_vec()[14:10]) > 1) begin
                miscompares++; $display("FAIL stale edge %0d got %h want %h", edges, dut_vec(), exp_vec());
            end
            if (sub_bytes_en === 1'b1) run++;
            else if (run != 0) begin
                vectors++;
                if (run != 2) begin
                    miscompares++; $display("FAIL stale_sub_dwell got %0d want 2", run);
                end
                run = 0;
            end
        end
        vectors++;
        if (edges != 82) begin
            miscompares++; $display("FAIL stale_latency got %0d want 82", edges);
        end
        tick(1'b0, 1'b1, 5'b0);
    endtask

    task automatic test_watchdog();
        int edges = 0, since = -1;
        tick(1'b1, 1'b0, 5'b0);
        while (error !== 1'b1 && done !== 1'b1 && edges < 300) begin
            logic [4:0] f = ideal_flags();
            if (cur_kind() == K_SHIFT && cur_rnd() == 3) f = 5'b0;
            tick(1'b0, 1'b0, f);
            edges++;
            if (since >= 0) since++;
            if (since < 0 && cur_kind() == K_SHIFT && cur_rnd() == 3) since = 0;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL watchdog edge %0d got %h want %h", edges, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (since != 16 || error !== 1'b1 || round_count !== 4'd3 || dut_vec()[14:10] !== 5'b0) begin
            miscompares++;
            $display("FAIL watchdog_err got since=%0d err=%b rc=%0d en=%b want 16 1 3 00000",
                     since, error, round_count, dut_vec()[14:10]);
        end
        tick(1'b0, 1'b1, 5'b0);
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL watchdog_ack got %h want 0000", dut_vec());
        end
    endtask

    task automatic test_coincide();
        int edges = 0;
        tick(1'b1, 1'b0, 5'b0);
        while (error !== 1'b1 && done !== 1'b1 && edges < 300) begin
            logic [4:0] f = ideal_flags();
            if (cur_kind() == K_MIX && cur_rnd() == 2)
                f = (m_dwell == TIMEOUT - 1) ? 5'b10000 : 5'b0;
            tick(1'b0, 1'b0, f);
            edges++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL coincide edge %0d got %h want %h", edges, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || edges != 82 + TIMEOUT - 2) begin
            miscompares++; $display("FAIL coincide_end got done=%b err=%b edges=%0d want 1 0 %0d",
                                   done, error, edges, 82 + TIMEOUT - 2);
        end
        tick(1'b0, 1'b1, 5'b0);
    endtask

    task automatic test_ignore();
        int edges = 0;
        tick(1'b0, 1'b1, 5'b0);
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL ack_in_idle got %h want 0000", dut_vec());
        end
        tick(1'b1, 1'b0, 5'b0);
        while (done !== 1'b1 && error !== 1'b1 && edges < 200) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ideal_flags());
            edges++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL busy_start edge %0d got %h want %h", edges, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 5'b11111);
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0 || round_count !== 4'd10) begin
                miscompares++; $display("FAIL done_hold got done=%b busy=%b rc=%0d want 1 0 10", done, busy, round_count);
            end
        end
        tick(1'b1, 1'b1, 5'b0);
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL done_ack_start got %h want 0000", dut_vec());
        end
        tick(1'b1, 1'b0, 5'b0);
        vectors++;
        if (key_expan_en !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL restart got key_en=%b busy=%b want 1 1", key_expan_en, busy);
        end
        while (done !== 1'b1 && error !== 1'b1 && edges < 400) begin
            tick(1'b0, 1'b0, ideal_flags());
            edges++;
        end
        tick(1'b0, 1'b1, 5'b0);
    endtask

    task automatic test_reset_mid();
        int edges = 0;
        tick(1'b1, 1'b0, 5'b0);
        while (!(cur_kind() == K_ARK && cur_rnd() == 5) && edges < 200) begin
            tick(1'b0, 1'b0, ideal_flags());
            edges++;
        end
        vectors++;
        if (add_roundkey_en !== 1'b1 || round_count !== 4'd5) begin
            miscompares++; $display("FAIL pre_reset got ark=%b rc=%0d want 1 5", add_roundkey_en, round_count);
        end
        #2 RST = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec() !== 15'd0) begin
            miscompares++; $display("FAIL reset_mid got %h want 0000", dut_vec());
        end
        @(negedge CLK);
        RST = 1'b1;
        edges = 0;
        tick(1'b1, 1'b0, 5'b0);
        while (done !== 1'b1 && error !== 1'b1 && edges < 200) begin
            tick(1'b0, 1'b0, ideal_flags());
            edges++;
        end
        vectors++;
        if (edges != 82 || done !== 1'b1) begin
            miscompares++; $display("FAIL reset_rerun got %0d edges want 82", edges);
        end
        tick(1'b0, 1'b1, 5'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            int p = ((i / 500) % 2 == 0) ? 60 : 8;
            logic [4:0] f;
            for (int b = 0; b < 5; b++) f[b] = ($urandom_range(0, 99) < p);
            tick(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25), f);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        build_seq();
        test_reset();
        test_nominal();
        test_stale();
        test_watchdog();
        test_coincide();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
